tri_decomp_ctrl: RTL and testbench
==================================

TRI_DECOMP_CTRL -- requirements
Module: tri_decomp_ctrl

Interface
REQ-001 Parameter: TW, 12, width of target operand.
REQ-002 Parameter: NW, 7, width of n and remainder results; SHALL satisfy NW*(NW+1)/2-sized coverage of TW (default pair fixed, others unsupported).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 target  input  TW  value to decompose; captured in the cycle start is accepted.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 busy  output  1  high in LOAD or SUB.
REQ-009 done  output  1  one-cycle pulse when results become valid.
REQ-010 n_out  output  NW  largest n with 1+2+...+n <= target.
REQ-011 rem_out  output  NW  target minus n(n+1)/2; always <= n.

Function
REQ-012 The block is the inverse of the triangular-sum accumulator: it subtracts 1, 2, 3, ... from target until the next step exceeds the running remainder.
REQ-013 States: IDLE, LOAD, SUB, DONE; encoded in 2 bits.
REQ-014 IDLE: ready=1; start=1 -> capture target into r, go LOAD; else stay.
REQ-015 LOAD: b <= 1, n <= 0, go SUB (one cycle, no subtraction).
REQ-016 SUB: if r >= b then r <= r-b, n <= b, b <= b+1, stay; else go DONE.
REQ-017 DONE: done=1 for exactly this cycle, n_out/rem_out updated from n/r, next state IDLE.
REQ-018 n_out and rem_out SHALL hold their last values from DONE until the next DONE; they are not disturbed by a new computation in progress.
REQ-019 Latency: start accepted at edge k -> done high in the cycle after edge k+n+2 (LOAD 1 cycle, SUB n+1 cycles).
REQ-020 start while not in IDLE SHALL be ignored; target changes after capture SHALL have no effect.
REQ-021 Subtraction and compare SHALL be unsigned, width TW; b SHALL be NW+1 bits internally so b never wraps for any TW=12 target.
REQ-022 target=0 -> n_out=0, rem_out=0, done two cycles after LOAD.
REQ-023 start held high continuously -> a new computation starts on every return to IDLE (one idle cycle between jobs).

Reset
REQ-024 reset=1 at a rising edge SHALL force state IDLE, r=0, b=0, n=0, n_out=0, rem_out=0; done=0, busy=0, ready=1 in the following cycle.
REQ-025 reset during LOAD/SUB/DONE SHALL abort the job with no done pulse and clear outputs as REQ-024.
REQ-026 reset has priority over start in the same cycle.

Configuration
REQ-027 Macro TRI_DECOMP_DBG_EN: when defined, outputs ps_out[1:0] (current state) and ns_out[1:0] (next state) SHALL exist, driven combinationally from the FSM; when undefined these ports SHALL be absent and function is otherwise identical.

Structure
REQ-028 Package tri_decomp_pkg SHALL hold the state enum (IDLE, LOAD, SUB, DONE) and the default TW/NW constants.
REQ-029 Datapath (r, b, n registers, subtractor, comparator) SHALL be split into sub-module tri_decomp_dp; FSM stays in tri_decomp_ctrl, with only load/step/cmp signals between them.

Verification
REQ-030 reset, start=1 target=10 -> done after 6 cycles in SUB/LOAD path, n_out=4, rem_out=0.
REQ-031 target=12 -> n_out=4, rem_out=2; target=0 -> n_out=0, rem_out=0.
REQ-032 target=4095 -> n_out=90, rem_out=0, done exactly 92 cycles after LOAD entered.
REQ-033 start pulsed with target=55 during SUB of a target=20 job -> ignored; job yields n_out=5, rem_out=5, single done.
REQ-034 reset asserted in 3rd SUB cycle of target=100 -> no done, ready=1 next cycle, n_out=0, rem_out=0.
REQ-035 Random targets 0..4095 vs. reference model: n(n+1)/2 <= target < (n+1)(n+2)/2 and rem=target-n(n+1)/2 on every done.

Source files
------------

// File: rtl/tri_decomp_pkg.sv
// tri_decomp_pkg: shared FSM state encoding and default widths for the triangular decomposer
package tri_decomp_pkg;
  localparam int TW_DEF = 12;
  localparam int NW_DEF = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SUB = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/tri_decomp_if.sv
// tri_decomp_if: request/result bundle; master drives start/target, slave returns status and results
interface tri_decomp_if import tri_decomp_pkg::*; #(parameter int TW = TW_DEF, parameter int NW = NW_DEF);
  logic          start;
  logic [TW-1:0] target;
  logic          ready;
  logic          busy;
  logic          done;
  logic [NW-1:0] n_out;
  logic [NW-1:0] rem_out;
  modport master (output start, target, input ready, busy, done, n_out, rem_out);
  modport slave  (input start, target, output ready, busy, done, n_out, rem_out);
endinterface

// File: rtl/tri_decomp_dp.sv
// tri_decomp_dp: remainder/step/count registers with the unsigned subtractor and r >= b comparator
module tri_decomp_dp import tri_decomp_pkg::*; #(parameter int TW = TW_DEF, parameter int NW = NW_DEF) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap,
  input  logic          load,
  input  logic          step,
  input  logic [TW-1:0] target,
  output logic          cmp,
  output logic [NW-1:0] n,
  output logic [TW-1:0] r
);
  // one extra bit on b so the step after the largest n never wraps
  logic [NW:0]   b;
  logic [TW-1:0] b_ext;
  assign b_ext = TW'(b);
  assign cmp = r >= b_ext;
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      b <= '0;
      n <= '0;
    end else begin
      if (cap) r <= target;
      else if (step) r <= r - b_ext;
      if (load) begin
        b <= (NW+1)'(1);
        n <= '0;
      end else if (step) begin
        b <= b + 1'b1;
        n <= b[NW-1:0];
      end
    end
  end
endmodule

// File: rtl/tri_decomp_ctrl.sv
// tri_decomp_ctrl: FSM finding the largest n with n(n+1)/2 <= target; TRI_DECOMP_DBG_EN exposes ps_out/ns_out
module tri_decomp_ctrl import tri_decomp_pkg::*; #(parameter int TW = TW_DEF, parameter int NW = NW_DEF) (
  input logic clk,
  input logic reset,
  tri_decomp_if.slave bus
`ifdef TRI_DECOMP_DBG_EN
  ,
  output logic [1:0] ps_out,
  output logic [1:0] ns_out
`endif
);
  state_t        state, ns;
  logic          cmp, cap, load, step, fin;
  logic [NW-1:0] n, n_q, rem_q;
  logic [TW-1:0] r;
  assign cap  = state == IDLE && bus.start;
  assign load = state == LOAD;
  assign step = state == SUB && cmp;
  assign fin  = state == SUB && !cmp;
  tri_decomp_dp #(.TW(TW), .NW(NW)) dp (
    .clk(clk), .rst(reset), .cap(cap), .load(load), .step(step),
    .target(bus.target), .cmp(cmp), .n(n), .r(r)
  );
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : ns;
  end
  always_comb begin
    ns = state;
    ns = state == IDLE ? (bus.start ? LOAD : IDLE) :
         state == LOAD ? SUB :
         state == SUB  ? (cmp ? SUB : DONE) : IDLE;
  end
  // results land on the SUB exit edge so they are valid while done is high
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q   <= '0;
      rem_q <= '0;
    end else if (fin) begin
      n_q   <= n;
      rem_q <= r[NW-1:0];
    end
  end
  assign bus.ready   = state == IDLE;
  assign bus.busy    = state == LOAD || state == SUB;
  assign bus.done    = state == DONE;
  assign bus.n_out   = n_q;
  assign bus.rem_out = rem_q;
`ifdef TRI_DECOMP_DBG_EN
  assign ps_out = state;
  assign ns_out = ns;
`endif
endmodule

// File: tb/tb_tri_decomp_ctrl.sv
// tb_tri_decomp_ctrl: directed vector table plus hand sequences for abort, ignored start and back-to-back jobs
module tb_tri_decomp_ctrl;
  typedef struct {logic [11:0] t; int n; int rem;} vec_t;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int failures = 0;
  vec_t vecs[12];
  tri_decomp_if bus();
`ifdef TRI_DECOMP_DBG_EN
  logic [1:0] ps, ns;
`endif
  tri_decomp_ctrl dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef TRI_DECOMP_DBG_EN
    , .ps_out(ps), .ns_out(ns)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  // called just after a negedge; returns at the negedge where done is first seen
  task automatic run_job(input logic [11:0] t, output int lat);
    bus.start = 1;
    bus.target = t;
    @(posedge clk);
    #1 bus.start = 0;
    bus.target = ~t;
    lat = 0;
    @(negedge clk);
    chk("busy_in_load", {31'd0, bus.busy}, 1);
    chk("ready_in_load", {31'd0, bus.ready}, 0);
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, dones, first, second, nn, rr;
    logic [11:0] t;
    vecs = '{'{12'd10, 4, 0}, '{12'd12, 4, 2}, '{12'd0, 0, 0}, '{12'd4095, 90, 0},
             '{12'd1, 1, 0}, '{12'd2, 1, 1}, '{12'd3, 2, 0}, '{12'd5, 2, 2},
             '{12'd20, 5, 5}, '{12'd100, 13, 9}, '{12'd4094, 89, 89}, '{12'd55, 10, 0}};
    bus.start = 0;
    bus.target = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 1);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_n", {25'd0, bus.n_out}, 0);
    chk("rst_rem", {25'd0, bus.rem_out}, 0);
    reset = 0;
    @(negedge clk);
    foreach (vecs[i]) begin
      run_job(vecs[i].t, lat);
      chk($sformatf("lat_t%0d", vecs[i].t), lat, vecs[i].n + 2);
      chk($sformatf("n_t%0d", vecs[i].t), {25'd0, bus.n_out}, vecs[i].n);
      chk($sformatf("rem_t%0d", vecs[i].t), {25'd0, bus.rem_out}, vecs[i].rem);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, bus.done}, 0);
      chk("ready_after_done", {31'd0, bus.ready}, 1);
      chk("n_hold", {25'd0, bus.n_out}, vecs[i].n);
    end
    for (int k = 0; k < 20; k++) begin
      t = 12'($urandom_range(0, 4095));
      run_job(t, lat);
      nn = int'(bus.n_out);
      rr = int'(bus.rem_out);
      chk("rnd_timeout", {31'd0, bus.done}, 1);
      chk("rnd_lower", {31'd0, nn * (nn + 1) / 2 <= int'(t)}, 1);
      chk("rnd_upper", {31'd0, int'(t) < (nn + 1) * (nn + 2) / 2}, 1);
      chk("rnd_rem", rr, int'(t) - nn * (nn + 1) / 2);
      @(negedge clk);
    end
    // start pulsed with another target mid-job is ignored
    bus.start = 1;
    bus.target = 12'd20;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (3) @(negedge clk);
    bus.start = 1;
    bus.target = 12'd55;
    @(negedge clk);
    bus.start = 0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        nn = int'(bus.n_out);
        rr = int'(bus.rem_out);
      end
    end
    chk("ign_dones", dones, 1);
    chk("ign_n", nn, 5);
    chk("ign_rem", rr, 5);
    // reset in the third SUB cycle of a target=100 job
    bus.start = 1;
    bus.target = 12'd100;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("abort_busy_before", {31'd0, bus.busy}, 1);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("abort_ready", {31'd0, bus.ready}, 1);
    chk("abort_n", {25'd0, bus.n_out}, 0);
    chk("abort_rem", {25'd0, bus.rem_out}, 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    // start held high: jobs repeat with one idle cycle between them
    bus.start = 1;
    bus.target = 12'd3;
    first = -1;
    second = -1;
    for (int c = 0; c < 40 && second < 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    chk("held_period", second - first, 6);
    chk("held_n", {25'd0, bus.n_out}, 2);
    // reset beats start in the same cycle
    while (!bus.ready) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_prio_ready", {31'd0, bus.ready}, 1);
    chk("rst_prio_busy", {31'd0, bus.busy}, 0);
    bus.start = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
